runway_light_seq: RTL and testbench
===================================

Name: runway_light_seq

Overview:
- Parametrised airport runway light sequencer; the next generation of the 3-LED hazard-light FSM.
- Drives N_LIGHTS lamps in one of three animated modes (calm/alternate, right-to-left chase, left-to-right chase), plus a freeze mode.
- Contains its own step prescaler, so the whole block runs on the raw board clock. No divided clock is used.
- Sits between the board switches (mode select, enable) and the LEDR bank.

Parameters:
- N_LIGHTS, 3: number of lamps; legal range 3..32.
- TICK_CYCLES, 12_500_000: clock cycles per animation step; must be ≥2. Bench uses 4.
- CNT_W, $clog2(TICK_CYCLES): prescaler counter width (derived; not overridden).

Ports:
- clock  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- mode  in  2  requested mode: 00 CALM, 01 CHASE_R2L, 10 CHASE_L2R, 11 HOLD
- enable  in  1  1 = prescaler runs; 0 = everything frozen
- lights  out  N_LIGHTS  lamp drive, bit 0 = rightmost lamp
- step  out  1  one-cycle pulse on the cycle lights is updated
- cur_mode  out  2  mode currently animating (never HOLD)

Behaviour:
- Reset, asynchronous, active-high clock:
  - lights = 0, step = 0, cur_mode = CALM, prescaler count = 0, chase position = 0, calm phase = A.
- Prescaler:
  - Count increments each clock while enable = 1.
  - When count == TICK_CYCLES-1 and enable = 1: count wraps to 0 and a step event fires.
  - enable = 0 holds count and suppresses step events.
- All updates to lights, cur_mode, position and phase happen only on step edges. step is registered high for the cycle after the update edge.
- First step occurs TICK_CYCLES enabled cycles after reset release.
- Mode is sampled only at the step edge. A change between steps has no effect until the next step.
- At a step edge, with m = sampled mode:
  - m == HOLD: lights, cur_mode, position and phase unchanged. step still pulses.
  - m != cur_mode (and not HOLD): cur_mode <= m, and lights load m's start pattern.
    - CALM start = pattern A, phase B next.
    - CHASE_R2L start = bit 0 only, position 0.
    - CHASE_L2R start = bit N-1 only, position N-1.
  - m == cur_mode: advance one step.
    - CALM: A and B alternate. A = bits 0 and N-1 set. B = all interior bits set.
    - CHASE_R2L: position+1, wrapping N-1 -> 0.
    - CHASE_L2R: position-1, wrapping 0 -> N-1.
- Returning from HOLD to the same cur_mode resumes from the frozen pattern. It does not restart.
- HOLD from reset: lights remain 0 until a non-HOLD mode is sampled.
- First non-HOLD step after reset:
  - CALM: lights = A, because cur_mode == CALM and phase starts at A.
  - Either chase: start pattern of that chase.
- Exactly one lamp is lit in chase modes. No lamps overlap in CALM.
- Reset mid-step: asynchronous clear applies immediately. The prescaler restarts from 0.
- Internal FSM states: CALM_A, CALM_B, CHASE (with position register, CNT of $clog2(N_LIGHTS) bits), plus an implicit frozen condition via HOLD. Unreachable encodings return to CALM_A.

Decomposition:
- Package runway_light_pkg:
  - mode_t enum (CALM, CHASE_R2L, CHASE_L2R, HOLD).
  - State enum.
  - Function calm_pattern(phase, N) returning the A/B vectors.
- Sub-module runway_tick_gen (parameter TICK_CYCLES; ports clock, reset, enable, tick) holds the prescaler.
- The top module holds the FSM, the position register and the output register.

Test Plan (N_LIGHTS=5, TICK_CYCLES=4):
1. Reset, mode=00, enable=1:
   - lights = 00000 for 4 cycles.
   - Then 10001, 01110, 10001 on successive steps, spaced 4 cycles apart.
   - step pulses at each update.
2. mode=01 from CALM: next step gives 00001, then 00010, 00100, 01000, 10000, 00001 (wrap).
3. mode=10: start 10000, then 01000 … 00001, 10000 (wrap). Switching 10->01 mid-chase restarts at 00001.
4. In CHASE_R2L at 00100, mode=11 for 3 steps:
   - lights stay 00100 and step still pulses.
   - Back to 01: the next step gives 01000 (resume, not restart).
5. Toggle enable=0 for 10 cycles mid-count: no step and lights frozen. Resume: the step lands exactly at the remaining count.
6. Assert reset asynchronously between clock edges while lights=01000: lights = 00000 immediately. After release, the first step arrives at 4 cycles with CALM 10001.

Source files
------------

// File: rtl/runway_light_pkg.sv
// Purpose: shared types and the CALM pattern helper for the runway light sequencer.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package runway_light_pkg;

  // Switch encoding of the requested animation mode.
  typedef enum logic [1:0] {
    CALM      = 2'b00,
    CHASE_R2L = 2'b01,
    CHASE_L2R = 2'b10,
    HOLD      = 2'b11
  } mode_t;

  // CALM_A / CALM_B name the pattern shown on the NEXT calm step.
  typedef enum logic [1:0] {
    CALM_A = 2'b00,
    CALM_B = 2'b01,
    CHASE  = 2'b10
  } state_t;

  // Phase 0 = pattern A (both end lamps), phase 1 = pattern B (all interior lamps).
  // Returned 32 bits wide; callers truncate to their lamp count.
  function automatic logic [31:0] calm_pattern(input logic phase, input int n);
    logic [31:0] ends;
    logic [31:0] mask;
    ends = 32'd1 | (32'd1 << (n - 1));
    mask = (n >= 32) ? '1 : ((32'd1 << n) - 32'd1);
    return phase ? (mask & ~ends) : ends;
  endfunction

endpackage

// File: rtl/runway_tick_gen.sv
// Purpose: step prescaler; fires tick once every TICK_CYCLES enabled clocks.
// Latency: tick is combinational, high during the TICK_CYCLES-th enabled cycle.
// Backpressure: enable = 0 holds the count and suppresses tick.
// Ports: clock, reset (async, active-high), enable, tick.
module runway_tick_gen #(
  parameter  int TICK_CYCLES = 12_500_000,
  localparam int CNT_W       = $clog2(TICK_CYCLES)
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  logic [CNT_W-1:0] count_q;
  logic             at_end;

  assign at_end = (count_q == CNT_W'(TICK_CYCLES - 1));
  assign tick   = enable && at_end;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= at_end ? '0 : count_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/runway_light_seq.sv
// Purpose: runway light sequencer: CALM alternation, R2L/L2R chase, HOLD freeze.
// Latency: lights/cur_mode update on the tick edge; step is high the following cycle.
// Backpressure: enable = 0 freezes the prescaler, so no step and no light change.
// Ports: clock, reset (async, active-high), mode[1:0], enable,
//        lights[N_LIGHTS-1:0] (bit 0 = rightmost), step, cur_mode[1:0].
module runway_light_seq
  import runway_light_pkg::*;
#(
  parameter int N_LIGHTS    = 3,
  parameter int TICK_CYCLES = 12_500_000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          mode,
  input  logic                enable,
  output logic [N_LIGHTS-1:0] lights,
  output logic                step,
  output logic [1:0]          cur_mode
);

  localparam int POS_W = $clog2(N_LIGHTS);
  localparam logic [POS_W-1:0]    LAST_POS = POS_W'(N_LIGHTS - 1);
  localparam logic [N_LIGHTS-1:0] PAT_A    = N_LIGHTS'(calm_pattern(1'b0, N_LIGHTS));
  localparam logic [N_LIGHTS-1:0] PAT_B    = N_LIGHTS'(calm_pattern(1'b1, N_LIGHTS));
  localparam logic [N_LIGHTS-1:0] LAMP0    = N_LIGHTS'(1);

  logic                tick;
  mode_t               m_req;
  state_t              state_q, state_d;
  mode_t               cur_mode_q, cur_mode_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [N_LIGHTS-1:0] lights_q, lights_d;
  logic                step_q;

  runway_tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_gen (
    .clock (clock),
    .reset (reset),
    .enable(enable),
    .tick  (tick)
  );

  assign m_req = mode_t'(mode);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= CALM_A;
      cur_mode_q <= CALM;
      pos_q      <= '0;
      lights_q   <= '0;
      step_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_mode_q <= cur_mode_d;
      pos_q      <= pos_d;
      lights_q   <= lights_d;
      step_q     <= tick;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_mode_d = cur_mode_q;
    pos_d      = pos_q;
    lights_d   = lights_q;

    // HOLD still lets step pulse (step_q follows tick) but freezes everything else.
    if (tick && (m_req != HOLD)) begin
      if (m_req != cur_mode_q) begin
        // Mode change: restart at the new mode's start pattern.
        cur_mode_d = m_req;
        case (m_req)
          CHASE_R2L: begin
            pos_d   = '0;
            state_d = CHASE;
          end
          CHASE_L2R: begin
            pos_d   = LAST_POS;
            state_d = CHASE;
          end
          default: begin
            lights_d = PAT_A;
            state_d  = CALM_B;
          end
        endcase
      end else begin
        case (state_q)
          CALM_A: begin
            lights_d = PAT_A;
            state_d  = CALM_B;
          end
          CALM_B: begin
            lights_d = PAT_B;
            state_d  = CALM_A;
          end
          CHASE: begin
            if (cur_mode_q == CHASE_R2L) begin
              pos_d = (pos_q == LAST_POS) ? '0 : pos_q + POS_W'(1);
            end else begin
              pos_d = (pos_q == '0) ? LAST_POS : pos_q - POS_W'(1);
            end
          end
          default: begin
            state_d = CALM_A;
          end
        endcase
      end
      if (state_d == CHASE) begin
        lights_d = LAMP0 << pos_d;
      end
    end
  end

  assign lights   = lights_q;
  assign step     = step_q;
  assign cur_mode = cur_mode_q;

endmodule

// File: tb/tb_runway_light_seq.sv
module tb_runway_light_seq;

  localparam int N = 5;
  localparam int T = 4;

  logic         clock;
  logic         reset;
  logic [1:0]   mode;
  logic         enable;
  logic [N-1:0] lights;
  logic         step;
  logic [1:0]   cur_mode;

  int checks;
  int errors;

  runway_light_seq #(
    .N_LIGHTS   (N),
    .TICK_CYCLES(T)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .mode    (mode),
    .enable  (enable),
    .lights  (lights),
    .step    (step),
    .cur_mode(cur_mode)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]   mode;
    logic [N-1:0] exp_lights;
    logic [1:0]   exp_mode;
  } vec_t;

  vec_t vecs[22];

  // Reference model: enabled-cycle counter, calm parity, chase position.
  int           m_cnt;
  int           m_pos;
  int           m_cur;
  bit           m_calm_b;
  logic [N-1:0] m_lights;
  bit           m_step;
  int           ends_i;
  int           inner_i;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    m_cnt    = 0;
    m_pos    = 0;
    m_cur    = 0;
    m_calm_b = 0;
    m_lights = '0;
    m_step   = 0;
  endtask

  task automatic model_step(input int md);
    if (md != 3) begin
      if (md != m_cur) begin
        m_cur = md;
        if (md == 0) begin
          m_lights = N'(ends_i);
          m_calm_b = 1;
        end else begin
          m_pos    = (md == 1) ? 0 : N - 1;
          m_lights = N'(1 << m_pos);
        end
      end else if (m_cur == 0) begin
        m_lights = m_calm_b ? N'(inner_i) : N'(ends_i);
        m_calm_b = !m_calm_b;
      end else begin
        m_pos    = (m_cur == 1) ? (m_pos + 1) % N : (m_pos + N - 1) % N;
        m_lights = N'(1 << m_pos);
      end
    end
  endtask

  task automatic model_clock(input int md, input bit en);
    m_step = 0;
    if (en) begin
      if (m_cnt == T - 1) begin
        m_cnt  = 0;
        m_step = 1;
        model_step(md);
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic set_vec(input int i, input logic [1:0] md, input logic [N-1:0] l, input logic [1:0] cm);
    vecs[i].mode       = md;
    vecs[i].exp_lights = l;
    vecs[i].exp_mode   = cm;
  endtask

  initial begin
    logic [N-1:0] prev;
    checks  = 0;
    errors  = 0;
    ends_i  = (1 << (N - 1)) | 1;
    inner_i = ((1 << N) - 1) ^ ends_i;

    set_vec(0,  2'b00, 5'b10001, 2'b00);
    set_vec(1,  2'b00, 5'b01110, 2'b00);
    set_vec(2,  2'b00, 5'b10001, 2'b00);
    set_vec(3,  2'b01, 5'b00001, 2'b01);
    set_vec(4,  2'b01, 5'b00010, 2'b01);
    set_vec(5,  2'b01, 5'b00100, 2'b01);
    set_vec(6,  2'b01, 5'b01000, 2'b01);
    set_vec(7,  2'b01, 5'b10000, 2'b01);
    set_vec(8,  2'b01, 5'b00001, 2'b01);
    set_vec(9,  2'b10, 5'b10000, 2'b10);
    set_vec(10, 2'b10, 5'b01000, 2'b10);
    set_vec(11, 2'b10, 5'b00100, 2'b10);
    set_vec(12, 2'b10, 5'b00010, 2'b10);
    set_vec(13, 2'b10, 5'b00001, 2'b10);
    set_vec(14, 2'b10, 5'b10000, 2'b10);
    set_vec(15, 2'b01, 5'b00001, 2'b01);
    set_vec(16, 2'b01, 5'b00010, 2'b01);
    set_vec(17, 2'b01, 5'b00100, 2'b01);
    set_vec(18, 2'b11, 5'b00100, 2'b01);
    set_vec(19, 2'b11, 5'b00100, 2'b01);
    set_vec(20, 2'b11, 5'b00100, 2'b01);
    set_vec(21, 2'b01, 5'b01000, 2'b01);

    // Reset state.
    reset  = 1'b1;
    mode   = 2'b00;
    enable = 1'b1;
    #2;
    check("reset_lights", 32'(lights), 32'h0);
    check("reset_step", 32'(step), 32'h0);
    check("reset_cur_mode", 32'(cur_mode), 32'h0);
    #10;
    reset = 1'b0;

    // Directed step table: every step lands exactly T cycles after the previous one.
    prev = '0;
    for (int i = 0; i < 22; i++) begin
      mode = vecs[i].mode;
      for (int c = 0; c < T - 1; c++) begin
        cycle();
        check($sformatf("tbl%0d_idle_step", i), 32'(step), 32'h0);
        check($sformatf("tbl%0d_idle_lights", i), 32'(lights), 32'(prev));
      end
      cycle();
      check($sformatf("tbl%0d_step", i), 32'(step), 32'h1);
      check($sformatf("tbl%0d_lights", i), 32'(lights), 32'(vecs[i].exp_lights));
      check($sformatf("tbl%0d_cur_mode", i), 32'(cur_mode), 32'(vecs[i].exp_mode));
      prev = vecs[i].exp_lights;
    end

    // Enable gap mid-count: step lands after the remaining enabled cycles only.
    mode = 2'b01;
    cycle();
    cycle();
    check("gap_pre_step", 32'(step), 32'h0);
    enable = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cycle();
      check("gap_frozen_step", 32'(step), 32'h0);
      check("gap_frozen_lights", 32'(lights), 32'h08);
    end
    enable = 1'b1;
    cycle();
    check("gap_resume_nostep", 32'(step), 32'h0);
    cycle();
    check("gap_resume_step", 32'(step), 32'h1);
    check("gap_resume_lights", 32'(lights), 32'h10);

    // Async reset between edges while lights = 01000.
    mode = 2'b10;
    repeat (T) cycle();
    check("l2r_restart", 32'(lights), 32'h10);
    repeat (T) cycle();
    check("pre_reset_lights", 32'(lights), 32'h08);
    cycle();
    #2 reset = 1'b1;
    #1;
    check("async_reset_lights", 32'(lights), 32'h0);
    check("async_reset_cur_mode", 32'(cur_mode), 32'h0);
    #1 reset = 1'b0;
    mode = 2'b00;
    for (int c = 0; c < T - 1; c++) begin
      cycle();
      check("post_reset_idle_step", 32'(step), 32'h0);
      check("post_reset_idle_lights", 32'(lights), 32'h0);
    end
    cycle();
    check("post_reset_step", 32'(step), 32'h1);
    check("post_reset_lights", 32'(lights), 32'h11);

    // Randomized run against the reference model.
    cycle();
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    model_reset();
    mode   = 2'($urandom_range(0, 3));
    enable = 1'b1;
    for (int it = 0; it < 1500; it++) begin
      int  md;
      bit  en;
      md = int'(mode);
      en = enable;
      cycle();
      model_clock(md, en);
      check("rnd_lights", 32'(lights), 32'(m_lights));
      check("rnd_step", 32'(step), 32'(m_step));
      check("rnd_cur_mode", 32'(cur_mode), 32'(m_cur));
      if ($urandom_range(0, 249) == 0) begin
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("rnd_async_reset", 32'(lights), 32'h0);
        #1 reset = 1'b0;
      end
      if ($urandom_range(0, 5) == 0) mode = 2'($urandom_range(0, 3));
      enable = ($urandom_range(0, 9) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
